ram2_ctrl: RTL and testbench
============================

# ram2_ctrl

Instruction-memory responder for the fetch stage. It accepts fetch requests (address from the program counter) and store requests targeting instruction space. It drives the external RAM2 SRAM control, address and data lines, and returns a registered instruction word with a one-cycle valid strobe. It sits between the fetch/PC logic and the RAM2 pins; tristating of the data bus happens at the top level.

## Interface

Parameters:
- `NOP_WORD`, default 16'h0800: instruction register value after reset. This is the ISA NOP.
- `SRAM_AW`, default 18: width of the SRAM address bus. The upper `SRAM_AW-16` bits are always driven zero.

Ports:
- `r2i_clk` in 1: sole clock; all state changes on its rising edge.
- `r2i_rst` in 1: asynchronous, active-high reset.
- `r2i_fetch_req` in 1: level request to fetch the word at `r2i_fetch_addr`.
- `r2i_fetch_addr` in 16: fetch word address.
- `r2i_fetch_flush` in 1: cancels the fetch currently in flight (branch/interrupt redirect).
- `r2i_wr_req` in 1: store request into RAM2.
- `r2i_wr_addr` in 16: store word address.
- `r2i_wr_data` in 16: store data.
- `r2i_sram_din` in 16: data read back from the RAM2 pins.
- `r2o_fetch_instr` out 16: registered fetched instruction.
- `r2o_fetch_valid` out 1: one-cycle strobe; `r2o_fetch_instr` updated this cycle.
- `r2o_wr_ack` out 1: store accepted; high for exactly one cycle.
- `r2o_busy` out 1: controller not able to accept a fetch this cycle.
- `r2o_sram_addr` out SRAM_AW: SRAM address.
- `r2o_sram_dout` out 16: SRAM write data.
- `r2o_sram_dout_en` out 1: top level drives `r2o_sram_dout` onto the pins when high.
- `r2o_sram_oe_n` out 1: SRAM output enable, active-low.
- `r2o_sram_we_n` out 1: SRAM write enable, active-low.
- `r2o_sram_en_n` out 1: SRAM chip enable, active-low.

## Operation

- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. Reset state is IDLE.
- IDLE transitions:
  - If `r2i_wr_req`: latch `r2i_wr_addr` and `r2i_wr_data`, go to WR_SETUP.
  - Else if `r2i_fetch_req`: latch `r2i_fetch_addr`, go to RD.
  - Else stay in IDLE.
  - Writes win over a simultaneous fetch; the fetch is served on a later IDLE.
- RD: `r2o_sram_oe_n`=0. On the next edge: capture `r2i_sram_din` into `r2o_fetch_instr`, pulse `r2o_fetch_valid`, return to IDLE.
- Flush: if `r2i_fetch_flush` is high in any RD cycle, the capture still occurs but `r2o_fetch_valid` stays 0. Flush in IDLE has no effect.
- WR_SETUP: address and data driven, `r2o_sram_dout_en`=1, `r2o_sram_we_n`=1.
- WR_PULSE: `r2o_sram_we_n`=0, address and data stable.
- WR_HOLD: `r2o_sram_we_n`=1, `r2o_sram_dout_en` still 1, `r2o_wr_ack`=1. Return to IDLE.
- `r2o_sram_oe_n` is never low while `r2o_sram_dout_en`=1.
- `r2o_busy` = (state≠IDLE) | `r2i_wr_req`.
- `r2o_sram_addr` = {zeros, latched 16-bit address}. It holds its last value in IDLE.
- `r2o_sram_en_n` = 0 at all times after reset.
- Write handshake: the requester holds `r2i_wr_req` until it samples `r2o_wr_ack`=1, then deasserts it. If `r2i_wr_req` is still high in the following IDLE cycle, a new write starts.
- Reset values (asynchronous, immediate):
  - state=IDLE
  - `r2o_fetch_instr`=NOP_WORD
  - `r2o_fetch_valid`=0, `r2o_wr_ack`=0
  - `r2o_sram_addr`=0, `r2o_sram_dout`=0, `r2o_sram_dout_en`=0
  - `r2o_sram_oe_n`=1, `r2o_sram_we_n`=1, `r2o_sram_en_n`=1
- Reset mid-write must raise `r2o_sram_we_n` and drop `r2o_sram_dout_en` without waiting for a clock edge.

## Timing

- Fetch latency: request seen at edge N (IDLE→RD). Instruction and valid appear after edge N+1.
- Maximum fetch rate: one word per 2 cycles.
- Write occupancy: 3 cycles (SETUP, PULSE, HOLD). The write-enable low pulse is exactly one clock cycle. There is one full cycle of address/data setup before it and one cycle of hold after it.
- `r2o_wr_ack` is Moore-decoded from WR_HOLD. `r2o_fetch_valid` is a registered pulse. No output depends combinationally on inputs except `r2o_busy`.
- `r2i_fetch_addr` changes after acceptance are ignored until the next IDLE.
- All SRAM control outputs are registered or state-decoded, so they are glitch-free.

## Test plan

- Reset: assert `r2i_rst` mid-WR_PULSE. Required, before any clock edge: `r2o_sram_we_n`=1, `r2o_sram_dout_en`=0, `r2o_fetch_instr`=16'h0800, all outputs at their reset values.
- Single fetch: set `r2i_fetch_addr`=16'h1234 with `r2i_sram_din`=16'hABCD. Required: `r2o_sram_addr`=18'h01234 and `r2o_sram_oe_n`=0 for one cycle; then `r2o_fetch_instr`=16'hABCD with `r2o_fetch_valid` high for 1 cycle.
- Back-to-back fetches: hold `r2i_fetch_req`=1 over addresses 0,1,2. Required: valid strobes every 2nd cycle, with instructions in order.
- Write: `r2i_wr_addr`=16'h0040, `r2i_wr_data`=16'h5A5A. Required sequence: SETUP (`r2o_sram_we_n`=1, `r2o_sram_dout_en`=1), PULSE (`r2o_sram_we_n`=0 for 1 cycle), HOLD (`r2o_wr_ack`=1). `r2o_sram_oe_n`=1 throughout.
- Collision: `r2i_wr_req` and `r2i_fetch_req` both high in IDLE. Required: the write completes first, then the RD for the fetch address; `r2o_busy` high the whole time.
- Flush: assert `r2i_fetch_flush` during RD. Required: `r2o_fetch_valid` stays 0, and the next request is accepted on the following IDLE.

Source files
------------

// File: rtl/ram2_ctrl.sv
// Instruction-memory responder: serves fetches from RAM2 and runs 3-cycle
// store sequences on the external SRAM pins (tristate lives at the top level).
module ram2_ctrl #(
  parameter logic [15:0] NOP_WORD = 16'h0800,
  parameter int          SRAM_AW  = 18
) (
  input  logic               r2i_clk,
  input  logic               r2i_rst,
  input  logic               r2i_fetch_req,
  input  logic [15:0]        r2i_fetch_addr,
  input  logic               r2i_fetch_flush,
  input  logic               r2i_wr_req,
  input  logic [15:0]        r2i_wr_addr,
  input  logic [15:0]        r2i_wr_data,
  input  logic [15:0]        r2i_sram_din,
  output logic [15:0]        r2o_fetch_instr,
  output logic               r2o_fetch_valid,
  output logic               r2o_wr_ack,
  output logic               r2o_busy,
  output logic [SRAM_AW-1:0] r2o_sram_addr,
  output logic [15:0]        r2o_sram_dout,
  output logic               r2o_sram_dout_en,
  output logic               r2o_sram_oe_n,
  output logic               r2o_sram_we_n,
  output logic               r2o_sram_en_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        en_n_q, en_n_d;

  always_ff @(posedge r2i_clk or posedge r2i_rst) begin
    if (r2i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      en_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      en_n_q  <= en_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    en_n_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Stores take priority; a pending fetch is picked up on a later IDLE.
        if (r2i_wr_req) begin
          addr_d  = r2i_wr_addr;
          dout_d  = r2i_wr_data;
          state_d = S_WR_SETUP;
        end else if (r2i_fetch_req) begin
          addr_d  = r2i_fetch_addr;
          state_d = S_RD;
        end
      end
      S_RD: begin
        // A flushed fetch still updates the word but is never announced.
        instr_d = r2i_sram_din;
        valid_d = ~r2i_fetch_flush;
        state_d = S_IDLE;
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: state_d = S_WR_HOLD;
      S_WR_HOLD:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so the async reset releases them at once.
  assign r2o_sram_oe_n    = (state_q != S_RD);
  assign r2o_sram_we_n    = (state_q != S_WR_PULSE);
  assign r2o_sram_dout_en = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) ||
                            (state_q == S_WR_HOLD);
  assign r2o_wr_ack       = (state_q == S_WR_HOLD);
  assign r2o_busy         = (state_q != S_IDLE) || r2i_wr_req;

  assign r2o_sram_addr    = {{(SRAM_AW-16){1'b0}}, addr_q};
  assign r2o_sram_dout    = dout_q;
  assign r2o_sram_en_n    = en_n_q;
  assign r2o_fetch_instr  = instr_q;
  assign r2o_fetch_valid  = valid_q;

endmodule

// File: tb/tb_ram2_ctrl.sv
// Bench for ram2_ctrl: behavioural SRAM on the pins plus a word-level memory
// model; directed scenarios followed by random fetch/store/flush traffic.
module tb_ram2_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_flush, wr_req;
  logic [15:0] fetch_addr, wr_addr, wr_data;
  logic [15:0] sram_din;
  logic [15:0] fetch_instr;
  logic        fetch_valid, wr_ack, busy;
  logic [17:0] sram_addr;
  logic [15:0] sram_dout;
  logic        sram_dout_en, sram_oe_n, sram_we_n, sram_en_n;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] sram_mem [0:65535];
  logic [15:0] ref_mem  [0:65535];

  always #5 clk = ~clk;

  ram2_ctrl dut (
    .r2i_clk         (clk),
    .r2i_rst         (rst),
    .r2i_fetch_req   (fetch_req),
    .r2i_fetch_addr  (fetch_addr),
    .r2i_fetch_flush (fetch_flush),
    .r2i_wr_req      (wr_req),
    .r2i_wr_addr     (wr_addr),
    .r2i_wr_data     (wr_data),
    .r2i_sram_din    (sram_din),
    .r2o_fetch_instr (fetch_instr),
    .r2o_fetch_valid (fetch_valid),
    .r2o_wr_ack      (wr_ack),
    .r2o_busy        (busy),
    .r2o_sram_addr   (sram_addr),
    .r2o_sram_dout   (sram_dout),
    .r2o_sram_dout_en(sram_dout_en),
    .r2o_sram_oe_n   (sram_oe_n),
    .r2o_sram_we_n   (sram_we_n),
    .r2o_sram_en_n   (sram_en_n)
  );

  // Asynchronous SRAM: read is combinational, write lands at the end of the WE pulse.
  assign sram_din = sram_mem[sram_addr[15:0]];
  always @(posedge clk) begin
    if (!sram_we_n && !sram_en_n && sram_dout_en)
      sram_mem[sram_addr[15:0]] <= sram_dout;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"},   32'(fetch_instr), 32'h0800);
    check({tag, "_valid"},   32'(fetch_valid), 32'h0);
    check({tag, "_ack"},     32'(wr_ack), 32'h0);
    check({tag, "_addr"},    32'(sram_addr), 32'h0);
    check({tag, "_dout"},    32'(sram_dout), 32'h0);
    check({tag, "_dout_en"}, 32'(sram_dout_en), 32'h0);
    check({tag, "_oe_n"},    32'(sram_oe_n), 32'h1);
    check({tag, "_we_n"},    32'(sram_we_n), 32'h1);
    check({tag, "_en_n"},    32'(sram_en_n), 32'h1);
  endtask

  // Starts from an IDLE cycle (1 time unit after an edge); ends in the next IDLE.
  task automatic do_fetch(input logic [15:0] a, input bit flush_rd, input bit flush_idle);
    fetch_req   = 1'b1;
    fetch_addr  = a;
    fetch_flush = flush_idle;
    tick();
    check("rd_oe_n",    32'(sram_oe_n), 32'h0);
    check("rd_addr",    32'(sram_addr), {16'h0, a});
    check("rd_busy",    32'(busy), 32'h1);
    check("rd_valid",   32'(fetch_valid), 32'h0);
    check("rd_dout_en", 32'(sram_dout_en), 32'h0);
    check("rd_we_n",    32'(sram_we_n), 32'h1);
    fetch_req   = 1'b0;
    fetch_addr  = 16'($urandom);
    fetch_flush = flush_rd;
    tick();
    fetch_flush = 1'b0;
    check("fe_valid", 32'(fetch_valid), 32'(!flush_rd));
    check("fe_instr", 32'(fetch_instr), 32'(ref_mem[a]));
    check("fe_oe_n",  32'(sram_oe_n), 32'h1);
    check("fe_busy",  32'(busy), 32'h0);
    check("fe_hold_addr", 32'(sram_addr), {16'h0, a});
  endtask

  // Leaves r2i_fetch_req untouched so a collision can be set up by the caller.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    #1;
    check("wr_req_busy", 32'(busy), 32'h1);
    tick();
    check("su_we_n",    32'(sram_we_n), 32'h1);
    check("su_dout_en", 32'(sram_dout_en), 32'h1);
    check("su_oe_n",    32'(sram_oe_n), 32'h1);
    check("su_addr",    32'(sram_addr), {16'h0, a});
    check("su_dout",    32'(sram_dout), 32'(d));
    check("su_ack",     32'(wr_ack), 32'h0);
    check("su_busy",    32'(busy), 32'h1);
    tick();
    check("pu_we_n",    32'(sram_we_n), 32'h0);
    check("pu_dout_en", 32'(sram_dout_en), 32'h1);
    check("pu_oe_n",    32'(sram_oe_n), 32'h1);
    check("pu_addr",    32'(sram_addr), {16'h0, a});
    check("pu_dout",    32'(sram_dout), 32'(d));
    check("pu_ack",     32'(wr_ack), 32'h0);
    tick();
    check("ho_we_n",    32'(sram_we_n), 32'h1);
    check("ho_dout_en", 32'(sram_dout_en), 32'h1);
    check("ho_oe_n",    32'(sram_oe_n), 32'h1);
    check("ho_ack",     32'(wr_ack), 32'h1);
    check("ho_busy",    32'(busy), 32'h1);
    wr_req     = 1'b0;
    wr_addr    = 16'($urandom);
    wr_data    = 16'($urandom);
    ref_mem[a] = d;
    tick();
    check("wi_ack",     32'(wr_ack), 32'h0);
    check("wi_dout_en", 32'(sram_dout_en), 32'h0);
    check("wi_we_n",    32'(sram_we_n), 32'h1);
    check("wi_valid",   32'(fetch_valid), 32'h0);
    check("wi_addr",    32'(sram_addr), {16'h0, a});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = 16'(i * 40503) ^ 16'h5A17;
      ref_mem[i]  = 16'(i * 40503) ^ 16'h5A17;
    end
    rst = 1'b1;
    fetch_req = 1'b0; fetch_flush = 1'b0; wr_req = 1'b0;
    fetch_addr = '0; wr_addr = '0; wr_data = '0;
    #2;
    check_reset_outputs("rst0");
    check("rst0_busy", 32'(busy), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("en_after_rst", 32'(sram_en_n), 32'h0);
    check("idle_oe_n",    32'(sram_oe_n), 32'h1);

    // Reset landing in the middle of the write-enable pulse.
    wr_req = 1'b1; wr_addr = 16'h0321; wr_data = 16'hBEEF;
    tick();
    tick();
    check("pre_rst_we_n", 32'(sram_we_n), 32'h0);
    rst = 1'b1;
    wr_req = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("en_after_rst2", 32'(sram_en_n), 32'h0);
    do_fetch(16'h0321, 1'b0, 1'b0);

    // Single fetch.
    sram_mem[16'h1234] = 16'hABCD;
    ref_mem[16'h1234]  = 16'hABCD;
    do_fetch(16'h1234, 1'b0, 1'b0);
    check("single_instr", 32'(fetch_instr), 32'hABCD);

    // Back-to-back fetches over 0,1,2 with the request held.
    fetch_req = 1'b1;
    fetch_addr = 16'd0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k % 2 == 1) begin
        check("b2b_rd_valid", 32'(fetch_valid), 32'h0);
        check("b2b_rd_oe_n",  32'(sram_oe_n), 32'h0);
        check("b2b_rd_addr",  32'(sram_addr), 32'((k - 1) / 2));
        fetch_addr = 16'((k + 1) / 2);
        if (k == 5) fetch_req = 1'b0;
      end else begin
        check("b2b_valid", 32'(fetch_valid), 32'h1);
        check("b2b_instr", 32'(fetch_instr), 32'(ref_mem[k / 2 - 1]));
      end
    end
    tick();
    check("b2b_end_valid", 32'(fetch_valid), 32'h0);

    // Write, then read the stored word back.
    do_write(16'h0040, 16'h5A5A);
    check("wr_mem", 32'(sram_mem[16'h0040]), 32'h5A5A);
    do_fetch(16'h0040, 1'b0, 1'b0);

    // Collision to the same address: the fetch must observe the new data.
    fetch_req = 1'b1;
    fetch_addr = 16'h0077;
    do_write(16'h0077, 16'hC0DE);
    do_fetch(16'h0077, 1'b0, 1'b0);

    // Flush during RD, then an immediate follow-up fetch; flush in IDLE is inert.
    do_fetch(16'h0200, 1'b1, 1'b0);
    do_fetch(16'h0201, 1'b0, 1'b1);

    for (int it = 0; it < 80; it++) begin
      int unsigned op;
      logic [15:0] a, fa, d;
      op = $urandom_range(0, 3);
      a  = 16'h0100 + 16'($urandom_range(0, 31));
      fa = 16'h0100 + 16'($urandom_range(0, 31));
      d  = 16'($urandom);
      case (op)
        0: do_write(a, d);
        1: do_fetch(a, 1'b0, 1'($urandom_range(0, 1)));
        2: do_fetch(a, 1'b1, 1'($urandom_range(0, 1)));
        default: begin
          fetch_req = 1'b1;
          fetch_addr = fa;
          do_write(a, d);
          do_fetch(fa, 1'b0, 1'b0);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
